// File: rtl/fetch_queue.sv
// IF/ID instruction fetch queue: DEPTH-entry circular buffer of {pc, instr} with PC back-pressure and flush.
// Optional FETCHQ_BYPASS_EN: zero-latency empty-queue bypass from fetch inputs to the id_* outputs.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PC_W-1:0]          fetch_pc,
    input  logic [INSTR_W-1:0]       fetch_instr,
    input  logic                     fetch_valid,
    output logic                     pc_write,
    input  logic                     flush,
    output logic [PC_W-1:0]          id_pc,
    output logic [INSTR_W-1:0]       id_instr,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic full_s;
    logic empty_s;
    logic byp_s;
    logic enq_s;
    logic deq_s;

    // Occupancy flags, derived from registered count only
    always_comb begin
        full_s  = (count_q == FULL_CNT);
        empty_s = (count_q == {CW{1'b0}});
    end

`ifdef FETCHQ_BYPASS_EN
    assign byp_s = empty_s & fetch_valid & ~flush;
`else
    assign byp_s = 1'b0;
`endif

    // A bypassed entry taken by decode the same cycle is never written
    always_comb begin
        enq_s = fetch_valid & ~full_s & ~flush & ~(byp_s & id_ready);
        deq_s = ~empty_s & id_ready & ~flush;
    end

    // Head presentation and PC back-pressure
    always_comb begin
        id_valid = ~empty_s | byp_s;
        pc_write = ~full_s;
        if (!empty_s) begin
            id_pc    = pc_mem[rd_ptr_q];
            id_instr = instr_mem[rd_ptr_q];
        end else if (byp_s) begin
            id_pc    = fetch_pc;
            id_instr = fetch_instr;
        end else begin
            id_pc    = {PC_W{1'b0}};
            id_instr = {INSTR_W{1'b0}};
        end
    end

    // Pointer and occupancy next state; flush overrides any handshake
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CW'(1'b1);
                2'b01:   count_d = count_q - CW'(1'b1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (enq_s) begin
            pc_mem[wr_ptr_q]    <= fetch_pc;
            instr_mem[wr_ptr_q] <= fetch_instr;
        end
    end

    assign count = count_q;

endmodule
